// File: rtl/keypad_pkg.sv
// Shared keypad matrix geometry, key-code types and the press-priority helper.
// Pure declarations: no state, no latency, no backpressure.
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int KEYS   = ROWS * COLS;
  localparam int CODE_W = 4;

  localparam logic [COLS-1:0] COL_RESET = 4'b1110;

  typedef logic [KEYS-1:0]   key_map_t;
  typedef logic [CODE_W-1:0] key_code_t;

  // Lowest index wins when several keys appear in the same frame.
  function automatic key_code_t lowest_set(input key_map_t v);
    lowest_set = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Column-step strobe: one-cycle tick every CLK_HZ/SCAN_HZ cycles, first tick
// CLK_HZ/SCAN_HZ cycles after reset; free-running, no backpressure.
module scan_tick_gen #(
  parameter int CLK_HZ  = 100000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with whole-frame debounce; key_valid one cycle after the
// deciding frame end, no backpressure. Optional auto-repeat under `KEY_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ          = 100000000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output key_code_t       key_code,
  output logic            key_valid,
  output key_map_t        key_map
);

  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 || REPEAT_FRAMES < 1) begin : g_param_check
    $error("keypad_scanner: DEBOUNCE_FRAMES must be 1..15 and REPEAT_FRAMES >= 1");
  end

  logic [ROWS-1:0] row_s1, row_sync;
  logic [1:0]      col_idx;
  logic [3:0]      stable_cnt;
  key_map_t        snap, last_frame, frame, map_next, new_keys;
  logic            tick, frame_end, match, update, rpt_fire;

  scan_tick_gen #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    frame = snap;
    frame[col_idx*ROWS +: ROWS] = ~row_sync;
    frame_end = tick && (col_idx == 2'(COLS - 1));
    match     = (frame == last_frame);
    update    = (DEBOUNCE_FRAMES == 1) ||
                (match && (int'(stable_cnt) >= DEBOUNCE_FRAMES - 2));
    map_next  = (frame_end && update) ? frame : key_map;
    new_keys  = map_next & ~key_map;
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(2 * REPEAT_FRAMES + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             single_key;

  always_comb begin
    single_key = (key_map != '0) && ((key_map & (key_map - 16'd1)) == '0);
    rpt_fire   = frame_end && (map_next == key_map) && single_key &&
                 (rpt_cnt == RPT_W'(2 * REPEAT_FRAMES - 1));
  end

  // After the first repeat the counter restarts half-way so later repeats come every period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt <= '0;
    end else if (frame_end) begin
      if (map_next != key_map || !single_key) begin
        rpt_cnt <= '0;
      end else if (rpt_fire) begin
        rpt_cnt <= RPT_W'(REPEAT_FRAMES);
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1     <= '1;
      row_sync   <= '1;
      col_idx    <= '0;
      col_out    <= COL_RESET;
      snap       <= '0;
      last_frame <= '0;
      stable_cnt <= '0;
      key_map    <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
    end else begin
      row_s1    <= row_in;
      row_sync  <= row_s1;
      key_valid <= 1'b0;
      if (tick) begin
        snap[col_idx*ROWS +: ROWS] <= ~row_sync;
        col_idx <= col_idx + 2'd1;
        col_out <= ~(4'b0001 << (col_idx + 2'd1));
      end
      if (frame_end) begin
        if (match) begin
          if (stable_cnt != 4'(DEBOUNCE_FRAMES - 1)) stable_cnt <= stable_cnt + 4'd1;
        end else begin
          stable_cnt <= '0;
          last_frame <= frame;
        end
        key_map <= map_next;
        if (new_keys != '0) begin
          key_valid <= 1'b1;
          key_code  <= lowest_set(new_keys);
        end else if (rpt_fire) begin
          key_valid <= 1'b1;
          key_code  <= lowest_set(key_map);
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad matrix model drives row_in from col_out,
// expected press events are queued when keys change and matched against key_valid.
module tb_keypad_scanner;

  localparam int FRAME = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid;
  logic [15:0] key_map;
  logic [15:0] pressed = '0;

  int edge_n;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] map;
    int          due;
  } exp_t;

  exp_t sb[$];

  keypad_scanner #(
    .CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_FRAMES(4), .REPEAT_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_map   (key_map)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_out[c] && pressed[c*4+r]) row_in[r] = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic exp_v;
    if (!rst) begin
      exp_v = (sb.size() > 0) && (sb[0].due == edge_n);
      check("key_valid", {31'b0, key_valid}, {31'b0, exp_v});
      if (exp_v) begin
        check("key_code", {28'b0, key_code}, {28'b0, sb[0].code});
        check("key_map_at_pulse", {16'b0, key_map}, {16'b0, sb[0].map});
        void'(sb.pop_front());
      end
    end
  end

  task automatic push(input logic [3:0] code, input logic [15:0] map, input int due);
    exp_t e;
    e.code = code; e.map = map; e.due = due;
    sb.push_back(e);
  endtask

  task automatic wait_boundary();
    do @(negedge clk); while (edge_n % FRAME != 0);
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  initial begin : stim
    int b;
    logic [3:0] col_exp [5];
    col_exp[0] = 4'b1110; col_exp[1] = 4'b1101; col_exp[2] = 4'b1011;
    col_exp[3] = 4'b0111; col_exp[4] = 4'b1110;

    // Reset state and column walk
    repeat (3) @(negedge clk);
    check("rst_col_out", {28'b0, col_out}, 32'hE);
    check("rst_key_code", {28'b0, key_code}, 0);
    check("rst_key_valid", {31'b0, key_valid}, 0);
    check("rst_key_map", {16'b0, key_map}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do @(negedge clk); while (edge_n != 5 + 10 * i);
      check("col_walk", {28'b0, col_out}, {28'b0, col_exp[i]});
    end
    wait_frames(5);

    // Clean press of key 6
    wait_boundary();
    b = edge_n;
    pressed = 16'h0040;
    push(4'd6, 16'h0040, b + 4 * FRAME);
    drain(400);
    pressed = '0;
    wait_frames(6);
    check("release_map_k6", {16'b0, key_map}, 0);

    // Key 6 bouncing for three frames (sampled 0,1,0), then stable
    wait_boundary();
    b = edge_n;
    for (int j = 0; j < 3 * FRAME; j++) begin
      pressed = ((j / 8) % 2 == 1) ? 16'h0040 : 16'h0000;
      @(negedge clk);
    end
    pressed = 16'h0040;
    push(4'd6, 16'h0040, b + 3 * FRAME + 4 * FRAME);
    drain(400);
    pressed = '0;
    wait_frames(6);
    check("release_map_bounce", {16'b0, key_map}, 0);

    // Keys 3 and 12 together: only the lower one is reported
    wait_boundary();
    b = edge_n;
    pressed = 16'h1008;
    push(4'd3, 16'h1008, b + 4 * FRAME);
    drain(400);
    pressed = '0;
    wait_frames(6);
    check("release_map_pair", {16'b0, key_map}, 0);

    // Reset mid-frame with key 6 held
    wait_boundary();
    b = edge_n;
    pressed = 16'h0040;
    push(4'd6, 16'h0040, b + 4 * FRAME);
    drain(400);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_col_out", {28'b0, col_out}, 32'hE);
    check("midrst_key_code", {28'b0, key_code}, 0);
    check("midrst_key_valid", {31'b0, key_valid}, 0);
    check("midrst_key_map", {16'b0, key_map}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(4'd6, 16'h0040, 4 * FRAME);
    drain(400);
    pressed = '0;
    wait_frames(6);
    check("release_map_rst", {16'b0, key_map}, 0);

`ifdef KEY_REPEAT_EN
    // Auto-repeat on key 9, stopped by adding key 0
    wait_boundary();
    b = edge_n;
    pressed = 16'h0200;
    push(4'd9, 16'h0200, b + 4 * FRAME);
    push(4'd9, 16'h0200, b + 8 * FRAME);
    push(4'd9, 16'h0200, b + 10 * FRAME);
    push(4'd9, 16'h0200, b + 12 * FRAME);
    push(4'd9, 16'h0200, b + 14 * FRAME);
    push(4'd0, 16'h0201, b + 16 * FRAME);
    do @(negedge clk); while (edge_n != b + 12 * FRAME);
    pressed = 16'h0201;
    drain(1000);
    wait_frames(8);
    check("repeat_two_keys_map", {16'b0, key_map}, 32'h0201);
    pressed = '0;
    wait_frames(6);
    check("release_map_repeat", {16'b0, key_map}, 0);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
